// File: rtl/sdram_aref_sched_pkg.sv
// Shared SDRAM command codes, address bit index and scheduler state type
// for the auto-refresh scheduler.
package sdram_aref_sched_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_WR   = 4'b0100;

  localparam int A10_IDX = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_TRP_W,
    ST_AREF,
    ST_RFC_W,
    ST_DONE
  } aref_state_t;

  function automatic int wait_width(input int trp, input int trfc);
    return $clog2(((trp > trfc) ? trp : trfc) + 1);
  endfunction

endpackage

// File: rtl/sdram_aref_sched_if.sv
// Refresh scheduler <-> arbiter / command mux signal bundle.
// master: the scheduler; slave: the arbiter and command mux side.
interface sdram_aref_sched_if #(
  parameter int ADDR_W = 13
);
  logic              init_done;
  logic              aref_en;
  logic              aref_req;
  logic              aref_urgent;
  logic              aref_busy;
  logic              ref_done;
  logic [3:0]        aref_cmd;
  logic [ADDR_W-1:0] sdram_addr;
  logic [3:0]        debt;
  logic              debt_ovf;

  modport master (
    input  init_done, aref_en,
    output aref_req, aref_urgent, aref_busy, ref_done,
           aref_cmd, sdram_addr, debt, debt_ovf
  );

  modport slave (
    output init_done, aref_en,
    input  aref_req, aref_urgent, aref_busy, ref_done,
           aref_cmd, sdram_addr, debt, debt_ovf
  );
endinterface

// File: rtl/sdram_aref_timer.sv
// Refresh interval counter plus owed-refresh (debt) counter with sticky
// overflow flag.
module sdram_aref_timer #(
  parameter int TREFI_CYC = 780,
  parameter int MAX_DEBT  = 8
) (
  input  logic       sclk,
  input  logic       srst,
  input  logic       i_init_done,
  input  logic       i_aref_issue,
  output logic [3:0] o_debt,
  output logic       o_debt_ovf
);
  localparam int CNT_W = $clog2(TREFI_CYC);

  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_debt;
  logic             r_ovf;
  logic             w_tick;
  logic             w_full;

  assign w_tick = i_init_done && (r_cnt == CNT_W'(TREFI_CYC - 1));
  assign w_full = (r_debt == 4'(MAX_DEBT));

  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      r_cnt  <= '0;
      r_debt <= '0;
      r_ovf  <= 1'b0;
    end else if (!i_init_done) begin
      r_cnt  <= '0;
      r_debt <= '0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      // A tick and an AREF in the same cycle cancel; neither saturates nor overflows.
      if (w_tick && !i_aref_issue) begin
        if (w_full) r_ovf <= 1'b1;
        else        r_debt <= r_debt + 1'b1;
      end else if (!w_tick && i_aref_issue && (r_debt != '0)) begin
        r_debt <= r_debt - 1'b1;
      end
    end
  end

  assign o_debt     = r_debt;
  assign o_debt_ovf = r_ovf;
endmodule

// File: rtl/sdram_aref_sched.sv
// SDRAM auto-refresh scheduler: drains accumulated refresh debt on grant.
// Define SDRAM_AREF_PRECHARGE_EN to prefix each sequence with PRECHARGE ALL + tRP.
module sdram_aref_sched
  import sdram_aref_sched_pkg::*;
#(
  parameter int TREFI_CYC = 780,
  parameter int TRP_CYC   = 2,
  parameter int TRFC_CYC  = 7,
  parameter int MAX_DEBT  = 8,
  parameter int URGENT_TH = 6,
  parameter int ADDR_W    = 13
) (
  input  logic                sclk,
  input  logic                srst,
  sdram_aref_sched_if.master  bus
);
  localparam int WAIT_W = wait_width(TRP_CYC, TRFC_CYC);

  aref_state_t       r_state;
  logic [WAIT_W-1:0] r_wait;
  logic [3:0]        r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic              r_busy;
  logic              r_done;
  logic [3:0]        w_debt;
  logic              w_debt_ovf;
  logic              w_issue;

  // Debt decrements at the end of the cycle the AREF command is on the bus.
  assign w_issue = (r_state == ST_AREF);

  sdram_aref_timer #(
    .TREFI_CYC (TREFI_CYC),
    .MAX_DEBT  (MAX_DEBT)
  ) u_timer (
    .sclk         (sclk),
    .srst         (srst),
    .i_init_done  (bus.init_done),
    .i_aref_issue (w_issue),
    .o_debt       (w_debt),
    .o_debt_ovf   (w_debt_ovf)
  );

  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      r_state <= ST_IDLE;
      r_wait  <= '0;
      r_cmd   <= CMD_NOP;
      r_addr  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_cmd  <= CMD_NOP;
      r_addr <= '0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.aref_en && (w_debt != '0)) begin
            r_busy <= 1'b1;
`ifdef SDRAM_AREF_PRECHARGE_EN
            r_state         <= ST_PRE;
            r_cmd           <= CMD_PRE;
            r_addr[A10_IDX] <= 1'b1;
`else
            r_state <= ST_AREF;
            r_cmd   <= CMD_AREF;
`endif
          end
        end
`ifdef SDRAM_AREF_PRECHARGE_EN
        ST_PRE: begin
          if (TRP_CYC <= 1) begin
            r_state <= ST_AREF;
            r_cmd   <= CMD_AREF;
          end else begin
            r_state <= ST_TRP_W;
            r_wait  <= WAIT_W'((TRP_CYC > 1) ? TRP_CYC - 2 : 0);
          end
        end
        ST_TRP_W: begin
          if (r_wait == '0) begin
            r_state <= ST_AREF;
            r_cmd   <= CMD_AREF;
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end
`endif
        ST_AREF: begin
          r_state <= ST_RFC_W;
          r_wait  <= WAIT_W'(TRFC_CYC - 2);
        end
        ST_RFC_W: begin
          if (r_wait != '0) begin
            r_wait <= r_wait - 1'b1;
          end else if (w_debt != '0) begin
            r_state <= ST_AREF;
            r_cmd   <= CMD_AREF;
          end else begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.aref_cmd    = r_cmd;
  assign bus.sdram_addr  = r_addr;
  assign bus.aref_busy   = r_busy;
  assign bus.ref_done    = r_done;
  assign bus.debt        = w_debt;
  assign bus.debt_ovf    = w_debt_ovf;
  assign bus.aref_req    = (w_debt != '0);
  assign bus.aref_urgent = (w_debt >= 4'(URGENT_TH));
endmodule

// File: tb/tb_sdram_aref_sched.sv
// Bench for sdram_aref_sched: timestamp-based reference model checked every
// cycle, directed refresh scenarios with literal pins, then randomized traffic.
module tb_sdram_aref_sched;
  localparam int TREFI = 780;
  localparam int TRP   = 2;
  localparam int TRFC  = 7;
  localparam int MAXD  = 8;
  localparam int URG   = 6;
`ifdef SDRAM_AREF_PRECHARGE_EN
  localparam bit PREC = 1'b1;
`else
  localparam bit PREC = 1'b0;
`endif

  logic sclk;
  logic srst;
  int   n_checks = 0;
  int   n_fail   = 0;

  sdram_aref_sched_if #(.ADDR_W(13)) bus ();

  sdram_aref_sched #(
    .TREFI_CYC (TREFI),
    .TRP_CYC   (TRP),
    .TRFC_CYC  (TRFC),
    .MAX_DEBT  (MAXD),
    .URGENT_TH (URG),
    .ADDR_W    (13)
  ) dut (
    .sclk (sclk),
    .srst (srst),
    .bus  (bus)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a refresh sequence is a set of scheduled cycle numbers
  // (PRE, next AREF, decision point, DONE) rather than a state machine.
  int m_cyc = 0, m_cnt = 0, m_debt = 0;
  int m_pre_at = -1, m_aref_at = -1, m_decide_at = -1, m_done_at = -1;
  bit m_ovf = 1'b0, m_seq = 1'b0;
  int md_old;
  bit m_tick, m_issue;

  always @(posedge sclk or posedge srst) begin
    if (srst) begin
      m_cyc = 0; m_cnt = 0; m_debt = 0; m_ovf = 1'b0; m_seq = 1'b0;
      m_pre_at = -1; m_aref_at = -1; m_decide_at = -1; m_done_at = -1;
    end else begin
      md_old  = m_debt;
      m_tick  = bus.init_done && (m_cnt == TREFI - 1);
      m_issue = (m_cyc == m_aref_at);
      if (!bus.init_done) begin
        m_cnt = 0; m_debt = 0;
      end else begin
        m_cnt = m_tick ? 0 : m_cnt + 1;
        if (m_tick && !m_issue) begin
          if (m_debt == MAXD) m_ovf = 1'b1; else m_debt++;
        end else if (m_issue && !m_tick && m_debt > 0) begin
          m_debt--;
        end
      end
      if (!m_seq) begin
        if (bus.aref_en && md_old != 0) begin
          m_seq = 1'b1;
          if (PREC) begin m_pre_at = m_cyc + 1; m_aref_at = m_cyc + 1 + TRP; end
          else m_aref_at = m_cyc + 1;
        end
      end else if (m_issue) begin
        m_decide_at = m_cyc + TRFC - 1;
      end else if (m_cyc == m_decide_at) begin
        if (md_old != 0) m_aref_at = m_cyc + 1; else m_done_at = m_cyc + 1;
      end else if (m_cyc == m_done_at) begin
        m_seq = 1'b0;
      end
      m_cyc++;
    end
  end

  logic [3:0]  e_cmd;
  logic [12:0] e_addr;
  always @(negedge sclk) begin
    e_cmd  = (m_cyc == m_pre_at) ? 4'b0010 : (m_cyc == m_aref_at) ? 4'b0001 : 4'b0111;
    e_addr = '0;
    if (m_cyc == m_pre_at) e_addr[10] = 1'b1;
    chk("aref_cmd",    int'(bus.aref_cmd),    int'(e_cmd));
    chk("sdram_addr",  int'(bus.sdram_addr),  int'(e_addr));
    chk("aref_req",    int'(bus.aref_req),    int'(m_debt != 0));
    chk("aref_urgent", int'(bus.aref_urgent), int'(m_debt >= URG));
    chk("aref_busy",   int'(bus.aref_busy),   int'(m_seq));
    chk("ref_done",    int'(bus.ref_done),    int'(m_cyc == m_done_at));
    chk("debt",        int'(bus.debt),        m_debt);
    chk("debt_ovf",    int'(bus.debt_ovf),    int'(m_ovf));
  end

  // Called at a negedge; grants for one cycle and observes until ref_done.
  task automatic grant_and_watch(output int n_aref, output int t_pre, output int t_aref1,
                                 output int t_last, output int t_done, output int n_busy,
                                 output int min_gap, output int max_gap);
    n_aref = 0; t_pre = -1; t_aref1 = -1; t_last = -1; t_done = -1; n_busy = 0;
    min_gap = 1000; max_gap = 0;
    bus.aref_en = 1'b1;
    for (int k = 1; k <= 300 && t_done < 0; k++) begin
      @(negedge sclk);
      bus.aref_en = 1'b0;
      if (bus.aref_busy) n_busy++;
      if (bus.aref_cmd == 4'b0010 && t_pre < 0) t_pre = k;
      if (bus.aref_cmd == 4'b0001) begin
        if (t_last >= 0) begin
          if (k - t_last < min_gap) min_gap = k - t_last;
          if (k - t_last > max_gap) max_gap = k - t_last;
        end else t_aref1 = k;
        t_last = k;
        n_aref++;
      end
      if (bus.ref_done) t_done = k;
    end
    chk("seq_completes", int'(t_done > 0), 1);
  endtask

  task automatic wait_debt(input int target, input int budget, input string nm);
    int k;
    k = 0;
    while (int'(bus.debt) != target && k < budget) begin
      @(negedge sclk);
      k++;
    end
    chk(nm, int'(bus.debt), target);
  endtask

  int na, tp, ta, tl, td, nb, gmin, gmax, k, hold, prob;

  initial begin
    srst = 1'b1;
    bus.init_done = 1'b0;
    bus.aref_en = 1'b0;
    repeat (3) @(negedge sclk);
    chk("reset_cmd",  int'(bus.aref_cmd), 7);
    chk("reset_debt", int'(bus.debt), 0);
    chk("reset_busy", int'(bus.aref_busy), 0);
    srst = 1'b0;
    @(negedge sclk);
    bus.init_done = 1'b1;

    // First tick latency
    k = 0;
    do begin @(negedge sclk); k++; end while (!bus.aref_req && k < 1000);
    chk("first_tick_latency", k, 780);
    chk("first_tick_debt", int'(bus.debt), 1);

    // Single refresh
    grant_and_watch(na, tp, ta, tl, td, nb, gmin, gmax);
    chk("single_pre_at",  tp, PREC ? 1 : -1);
    chk("single_aref_at", ta, PREC ? 3 : 1);
    chk("single_done_at", td, PREC ? 10 : 8);
    chk("single_busy",    nb, PREC ? 10 : 8);
    chk("single_n_aref",  na, 1);
    chk("single_debt",    int'(bus.debt), 0);

    // Urgent threshold then drain
    wait_debt(5, 6 * TREFI, "wait_debt5");
    chk("urgent_below", int'(bus.aref_urgent), 0);
    wait_debt(6, 2 * TREFI, "wait_debt6");
    chk("urgent_at6", int'(bus.aref_urgent), 1);
    grant_and_watch(na, tp, ta, tl, td, nb, gmin, gmax);
    chk("drain6_n_aref", na, 6);
    chk("drain6_min_gap", gmin, 7);
    chk("drain6_max_gap", gmax, 7);
    chk("drain6_done_gap", td - tl, 7);

    // Saturation and sticky overflow
    k = 0;
    while (!bus.debt_ovf && k < 10 * TREFI) begin @(negedge sclk); k++; end
    chk("ovf_set", int'(bus.debt_ovf), 1);
    chk("ovf_debt_sat", int'(bus.debt), 8);
    grant_and_watch(na, tp, ta, tl, td, nb, gmin, gmax);
    chk("drain8_n_aref", na, 8);
    chk("ovf_sticky", int'(bus.debt_ovf), 1);

    // Tick coinciding with AREF issue
    wait_debt(1, 2 * TREFI, "wait_debt_tick");
    k = 0;
    while (m_cnt != (PREC ? TREFI - 2 - TRP : TREFI - 2) && k < 2 * TREFI) begin
      @(negedge sclk); k++;
    end
    grant_and_watch(na, tp, ta, tl, td, nb, gmin, gmax);
    chk("coincide_n_aref", na, 2);

    // Reset in the middle of tRFC wait
    wait_debt(1, 2 * TREFI, "wait_debt_rst");
    bus.aref_en = 1'b1;
    k = 0;
    do begin @(negedge sclk); bus.aref_en = 1'b0; k++; end
    while (bus.aref_cmd != 4'b0001 && k < 20);
    repeat (2) @(negedge sclk);
    chk("pre_rst_busy", int'(bus.aref_busy), 1);
    #2 srst = 1'b1;
    #1;
    chk("rst_cmd_nop", int'(bus.aref_cmd), 7);
    chk("rst_busy",    int'(bus.aref_busy), 0);
    chk("rst_debt",    int'(bus.debt), 0);
    @(negedge sclk);
    srst = 1'b0;
    bus.aref_en = 1'b1;
    @(negedge sclk);
    bus.aref_en = 1'b0;
    @(negedge sclk);
    chk("grant_no_debt_ignored", int'(bus.aref_busy), 0);

    // Randomized traffic
    hold = 0;
    prob = 0;
    for (int i = 0; i < 12000; i++) begin
      @(negedge sclk);
      if (i % 1000 == 0) begin
        case ($urandom_range(0, 2))
          0: prob = 0;
          1: prob = 50;
          default: prob = 4;
        endcase
      end
      bus.aref_en = (prob != 0) && ($urandom_range(1, prob) == 1);
      if (hold > 0) begin
        hold--;
        if (hold == 0) bus.init_done = 1'b1;
      end else if ($urandom_range(0, 1999) == 0) begin
        bus.init_done = 1'b0;
        hold = $urandom_range(1, 30);
      end
      if ($urandom_range(0, 2999) == 0) begin
        #2 srst = 1'b1;
        @(negedge sclk);
        srst = 1'b0;
      end
    end

    bus.aref_en = 1'b0;
    @(negedge sclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
